com_tx_sched: RTL and testbench

- Packet scheduler in front of the packet transmitter (fs/fd handshake, btype, ram_addr_init, tx_dlen). Arbitrates three requesters by fixed priority: handshake (ACK/NAK/STL) > status (DLINK/DTYPE/DTEMP) > data.
- Manages the DATA0/DATA1 toggle, enforces an inter-packet gap, and aborts a transmitter that never finishes.

---
 rtl/com_tx_sched_if.sv | 48 ++++
 rtl/com_tx_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_com_tx_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/com_tx_sched_if.sv
// com_tx_sched_if
//   Groups every non-clock signal of the packet scheduler: the three
//   requester handshakes (handshake, status, data), the data-toggle clear,
//   the transmitter fs/fd handshake with its packet descriptor, and the
//   err/busy status outputs.
//   master : scheduler side (drives done pulses, tx descriptor, err, busy)
//   slave  : environment side (requesters and transmitter)
interface com_tx_sched_if;
   // handshake requester
   logic        hs_req;
   logic [1:0]  hs_type;
   logic        hs_done;
   // status requester
   logic        st_req;
   logic [1:0]  st_type;
   logic [11:0] st_addr;
   logic [11:0] st_len;
   logic        st_done;
   // data requester
   logic        dt_req;
   logic [11:0] dt_addr;
   logic [11:0] dt_len;
   logic        dt_done;
   logic        tgl_clr;
   // transmitter
   logic        tx_fs;
   logic        tx_fd;
   logic [3:0]  tx_btype;
   logic [11:0] tx_addr;
   logic [11:0] tx_dlen;
   // status
   logic        err;
   logic        busy;

   modport master (
      input  hs_req, hs_type, st_req, st_type, st_addr, st_len,
             dt_req, dt_addr, dt_len, tgl_clr, tx_fd,
      output hs_done, st_done, dt_done, tx_fs, tx_btype, tx_addr, tx_dlen,
             err, busy
   );

   modport slave (
      output hs_req, hs_type, st_req, st_type, st_addr, st_len,
             dt_req, dt_addr, dt_len, tgl_clr, tx_fd,
      input  hs_done, st_done, dt_done, tx_fs, tx_btype, tx_addr, tx_dlen,
             err, busy
   );
endinterface

// File: rtl/com_tx_sched.sv
// com_tx_sched
//   Packet scheduler in front of the packet transmitter. Arbitrates three
//   requesters by fixed priority (handshake > status > data), drives the
//   transmitter fs/fd handshake with a stable descriptor (btype, address,
//   length), keeps the DATA0/DATA1 toggle, inserts an inter-packet gap and
//   aborts a transmitter that never raises fd.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-high
//     bus  - com_tx_sched_if.master (requesters, transmitter, err, busy)
//   Parameters:
//     GAP_CYC - idle cycles between leaving release and the next arbitration
//               (0 still spends one cycle in GAP)
//     TIMEOUT - max cycles tx_fs may stay high without tx_fd
//   All outputs are registered.
module com_tx_sched #(
   parameter int          GAP_CYC = 4,
   parameter logic [15:0] TIMEOUT = 16'd8192
) (
   input  logic             clk,
   input  logic             rst,
   com_tx_sched_if.master   bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_RELS = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_HS   = 2'd1;
   localparam logic [1:0] OWN_ST   = 2'd2;
   localparam logic [1:0] OWN_DT   = 2'd3;

   // Last value of the gap counter before returning to IDLE; a zero gap
   // still costs the single GAP cycle.
   localparam logic [15:0] GAP_LAST = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic        tgl_q, tgl_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] gap_q, gap_d;
   logic [3:0]  btype_q, btype_d;
   logic [11:0] addr_q, addr_d;
   logic [11:0] dlen_q, dlen_d;
   logic        fs_q, fs_d;
   logic [2:0]  done_q, done_d;   // {hs, st, dt}
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   // One-hot done vector {hs, st, dt} for the current owner.
   function automatic logic [2:0] done_vec(input logic [1:0] own);
      case (own)
         OWN_HS:  return 3'b100;
         OWN_ST:  return 3'b010;
         OWN_DT:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Packet type code for the owner; status and handshake codes embed the
   // requester's type field directly.
   function automatic logic [3:0] pick_btype(input logic [1:0] own,
                                             input logic [1:0] hs_t,
                                             input logic [1:0] st_t,
                                             input logic       tgl);
      case (own)
         OWN_HS:  return {2'b00, hs_t};
         OWN_ST:  return {2'b10, st_t};
         OWN_DT:  return tgl ? 4'b1110 : 4'b1101;
         default: return 4'b0000;
      endcase
   endfunction

   // Request is unusable: bad type code or empty payload.
   function automatic logic req_bad(input logic [1:0]  own,
                                    input logic [1:0]  hs_t,
                                    input logic [1:0]  st_t,
                                    input logic [11:0] st_l,
                                    input logic [11:0] dt_l);
      case (own)
         OWN_HS:  return (hs_t == 2'd0);
         OWN_ST:  return (st_t == 2'd3) || (st_l == 12'd0);
         OWN_DT:  return (dt_l == 12'd0);
         default: return 1'b1;
      endcase
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      tgl_d   = tgl_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      btype_d = btype_q;
      addr_d  = addr_q;
      dlen_d  = dlen_q;
      fs_d    = 1'b0;
      done_d  = 3'b000;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.hs_req) begin
               owner_d = OWN_HS;
               state_d = ST_LOAD;
            end else if (bus.st_req) begin
               owner_d = OWN_ST;
               state_d = ST_LOAD;
            end else if (bus.dt_req) begin
               owner_d = OWN_DT;
               state_d = ST_LOAD;
            end else begin
               owner_d = OWN_NONE;
            end
         end

         ST_LOAD: begin
            if (req_bad(owner_q, bus.hs_type, bus.st_type, bus.st_len, bus.dt_len)) begin
               // Rejected: the packet never reaches the transmitter.
               err_d   = 1'b1;
               done_d  = done_vec(owner_q);
               gap_d   = 16'd0;
               state_d = ST_GAP;
            end else begin
               btype_d = pick_btype(owner_q, bus.hs_type, bus.st_type, tgl_q);
               if (owner_q == OWN_ST) begin
                  addr_d = bus.st_addr;
                  dlen_d = bus.st_len;
               end else if (owner_q == OWN_DT) begin
                  addr_d = bus.dt_addr;
                  dlen_d = bus.dt_len;
               end else begin
                  addr_d = 12'd0;
                  dlen_d = 12'd0;
               end
               timer_d = 16'd0;
               fs_d    = 1'b1;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            fs_d    = 1'b1;
            timer_d = timer_q + 16'd1;
            if (bus.tx_fd) begin
               fs_d    = 1'b0;
               done_d  = done_vec(owner_q);
               state_d = ST_RELS;
               if (owner_q == OWN_DT) begin
                  tgl_d = ~tgl_q;
               end else begin
                  tgl_d = tgl_q;
               end
            end else if (timer_q == (TIMEOUT - 16'd1)) begin
               // Transmitter never finished: abort, toggle left as is.
               fs_d    = 1'b0;
               err_d   = 1'b1;
               done_d  = done_vec(owner_q);
               state_d = ST_RELS;
            end else begin
               state_d = ST_SEND;
            end
         end

         ST_RELS: begin
            if (!bus.tx_fd) begin
               timer_d = 16'd0;
               gap_d   = 16'd0;
               btype_d = 4'b0000;
               addr_d  = 12'd0;
               dlen_d  = 12'd0;
               state_d = ST_GAP;
            end else begin
               state_d = ST_RELS;
            end
         end

         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               owner_d = OWN_NONE;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end

         default: begin
            owner_d = OWN_NONE;
            state_d = ST_IDLE;
         end
      endcase

      // Clear wins over a same-cycle flip; a packet already loaded keeps
      // the btype it was given.
      if (bus.tgl_clr) begin
         tgl_d = 1'b0;
      end else begin
         tgl_d = tgl_d;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset drops tx_fs immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         tgl_q   <= 1'b0;
         timer_q <= 16'd0;
         gap_q   <= 16'd0;
         btype_q <= 4'b0000;
         addr_q  <= 12'd0;
         dlen_q  <= 12'd0;
         fs_q    <= 1'b0;
         done_q  <= 3'b000;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         tgl_q   <= tgl_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         btype_q <= btype_d;
         addr_q  <= addr_d;
         dlen_q  <= dlen_d;
         fs_q    <= fs_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.tx_fs    = fs_q;
   assign bus.tx_btype = btype_q;
   assign bus.tx_addr  = addr_q;
   assign bus.tx_dlen  = dlen_q;
   assign bus.hs_done  = done_q[2];
   assign bus.st_done  = done_q[1];
   assign bus.dt_done  = done_q[0];
   assign bus.err      = err_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_com_tx_sched.sv
// tb_com_tx_sched
//   Directed stimulus with a scoreboard: expected packets and expected
//   done/err events are queued when a request is issued; a monitor sampling
//   1 time unit after each rising edge pops and compares them.
module tb_com_tx_sched;
   localparam int          GAP_CYC = 4;
   localparam logic [15:0] TIMEOUT = 16'd8192;
   localparam int          BUDGET  = 20000;

   typedef struct packed {
      logic [3:0]  bt;
      logic [11:0] addr;
      logic [11:0] dlen;
      logic [15:0] fs_cyc;
   } pkt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   com_tx_sched_if bus ();

   com_tx_sched #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   pkt_t       pkt_q[$];
   logic [3:0] done_q[$];   // {err, hs, st, dt}
   int fd_after = 0;        // 0: transmitter never answers
   int rise_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transmitter model: fd rises after fd_after cycles of fs, held while fs.
   int tx_cnt = 0;
   always @(negedge clk) begin
      if (bus.tx_fs) begin
         tx_cnt++;
         if (fd_after != 0 && tx_cnt >= fd_after) bus.tx_fd = 1'b1;
      end else begin
         tx_cnt    = 0;
         bus.tx_fd = 1'b0;
      end
   end

   // Monitor / scoreboard.
   int   cyc = 0;
   int   last_fall = 0;
   bit   have_fall = 0;
   bit   in_pkt = 0;
   int   fs_len = 0;
   logic fs_prev = 1'b0, fd_prev = 1'b0;
   pkt_t cur;
   logic [3:0] ev, e;
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         in_pkt  = 0;
         fs_prev = 1'b0;
         fd_prev = bus.tx_fd;
      end else begin
         ev = {bus.err, bus.hs_done, bus.st_done, bus.dt_done};
         if (ev != 4'b0000) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", {28'd0, ev}, 32'd0);
            end else begin
               e = done_q.pop_front();
               chk("done_event", {28'd0, ev}, {28'd0, e});
            end
         end
         if (bus.tx_fs && !fs_prev) begin
            rise_cnt++;
            if (have_fall) begin
               n_cmp++;
               if (cyc - last_fall < GAP_CYC) begin
                  n_bad++;
                  $display("FAIL gap: got %0d cycles need >= %0d", cyc - last_fall, GAP_CYC);
               end
            end
            if (pkt_q.size() == 0) begin
               chk("fs_unexpected", 32'd1, 32'd0);
               in_pkt = 0;
            end else begin
               cur = pkt_q.pop_front();
               chk("btype", {28'd0, bus.tx_btype}, {28'd0, cur.bt});
               chk("addr",  {20'd0, bus.tx_addr},  {20'd0, cur.addr});
               chk("dlen",  {20'd0, bus.tx_dlen},  {20'd0, cur.dlen});
               in_pkt = 1;
            end
            fs_len = 1;
         end else if (bus.tx_fs) begin
            fs_len++;
            if (in_pkt) begin
               chk("btype_stable", {28'd0, bus.tx_btype}, {28'd0, cur.bt});
            end
         end else if (fs_prev && in_pkt) begin
            chk("fs_len", fs_len, {16'd0, cur.fs_cyc});
            in_pkt = 0;
         end
         if (!bus.tx_fd && fd_prev) begin
            last_fall = cyc;
            have_fall = 1;
         end
         fs_prev = bus.tx_fs;
         fd_prev = bus.tx_fd;
      end
   end

   // Wait for the selected requester's done (0=hs 1=st 2=dt), then drop req.
   task automatic serve(input int which);
      bit seen = 0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if ((which == 0 && bus.hs_done) || (which == 1 && bus.st_done) ||
             (which == 2 && bus.dt_done)) begin
            seen = 1;
            break;
         end
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      if (which == 0) bus.hs_req = 1'b0;
      else if (which == 1) bus.st_req = 1'b0;
      else bus.dt_req = 1'b0;
   endtask

   task automatic data_pkt(input logic [11:0] a, input logic [11:0] l,
                           input logic [3:0] bt, input int d);
      fd_after = d;
      pkt_q.push_back({bt, a, l, 16'(d)});
      done_q.push_back(4'b0001);
      @(negedge clk);
      bus.dt_addr = a;
      bus.dt_len  = l;
      bus.dt_req  = 1'b1;
      serve(2);
   endtask

   initial begin
      int r0;
      bit seen;
      bus.hs_req = 1'b0; bus.hs_type = 2'd0;
      bus.st_req = 1'b0; bus.st_type = 2'd0; bus.st_addr = 12'd0; bus.st_len = 12'd0;
      bus.dt_req = 1'b0; bus.dt_addr = 12'd0; bus.dt_len = 12'd0;
      bus.tgl_clr = 1'b0; bus.tx_fd = 1'b0;

      // Reset state
      #12;
      chk("rst_fs",    {31'd0, bus.tx_fs}, 32'd0);
      chk("rst_btype", {28'd0, bus.tx_btype}, 32'd0);
      chk("rst_addr",  {20'd0, bus.tx_addr}, 32'd0);
      chk("rst_dlen",  {20'd0, bus.tx_dlen}, 32'd0);
      chk("rst_done",  {29'd0, bus.hs_done, bus.st_done, bus.dt_done}, 32'd0);
      chk("rst_err",   {31'd0, bus.err}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Data toggle: DATA0 then DATA1
      data_pkt(12'h100, 12'h040, 4'b1101, 80);
      data_pkt(12'h100, 12'h040, 4'b1110, 80);

      // Three simultaneous requests, served in priority order
      fd_after = 10;
      pkt_q.push_back({4'b0010, 12'h000, 12'h000, 16'd10});
      pkt_q.push_back({4'b1001, 12'h200, 12'h010, 16'd10});
      pkt_q.push_back({4'b1101, 12'h300, 12'h020, 16'd10});
      done_q.push_back(4'b0100);
      done_q.push_back(4'b0010);
      done_q.push_back(4'b0001);
      @(negedge clk);
      bus.hs_type = 2'd2; bus.hs_req = 1'b1;
      bus.st_type = 2'd1; bus.st_addr = 12'h200; bus.st_len = 12'h010; bus.st_req = 1'b1;
      bus.dt_addr = 12'h300; bus.dt_len = 12'h020; bus.dt_req = 1'b1;
      fork
         serve(0);
         serve(1);
         serve(2);
      join

      // Zero-length status: err with st_done, no fs
      r0 = rise_cnt;
      done_q.push_back(4'b1010);
      @(negedge clk);
      bus.st_type = 2'd0; bus.st_addr = 12'h050; bus.st_len = 12'd0; bus.st_req = 1'b1;
      serve(1);
      repeat (10) @(negedge clk);
      chk("st_len0_no_fs", rise_cnt - r0, 32'd0);

      // Handshake type 0: err with hs_done, no fs
      r0 = rise_cnt;
      done_q.push_back(4'b1100);
      @(negedge clk);
      bus.hs_type = 2'd0; bus.hs_req = 1'b1;
      serve(0);
      repeat (10) @(negedge clk);
      chk("hs_type0_no_fs", rise_cnt - r0, 32'd0);

      // Timeout: DATA1 pending, aborted after TIMEOUT cycles, toggle kept
      fd_after = 0;
      pkt_q.push_back({4'b1110, 12'h400, 12'h008, TIMEOUT});
      done_q.push_back(4'b1001);
      @(negedge clk);
      bus.dt_addr = 12'h400; bus.dt_len = 12'h008; bus.dt_req = 1'b1;
      serve(2);
      data_pkt(12'h410, 12'h001, 4'b1110, 5);

      // tgl_clr after two further packets
      data_pkt(12'hFFF, 12'hFFF, 4'b1101, 3);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            seen = 1;
            break;
         end
      end
      chk("idle_before_clr", {31'd0, seen}, 32'd1);
      bus.tgl_clr = 1'b1;
      @(negedge clk);
      bus.tgl_clr = 1'b0;
      data_pkt(12'h020, 12'h004, 4'b1101, 4);

      // Reset mid-packet: DATA1 in flight, then DATA0 after release
      fd_after = 0;
      pkt_q.push_back({4'b1110, 12'h700, 12'h030, 16'd0});
      @(negedge clk);
      bus.dt_addr = 12'h700; bus.dt_len = 12'h030; bus.dt_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tx_fs) begin
            seen = 1;
            break;
         end
      end
      chk("fs_before_rst", {31'd0, seen}, 32'd1);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_fs",    {31'd0, bus.tx_fs}, 32'd0);
      chk("midrst_btype", {28'd0, bus.tx_btype}, 32'd0);
      chk("midrst_addr",  {20'd0, bus.tx_addr}, 32'd0);
      chk("midrst_busy",  {31'd0, bus.busy}, 32'd0);
      fd_after = 12;
      pkt_q.push_back({4'b1101, 12'h700, 12'h030, 16'd12});
      done_q.push_back(4'b0001);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      serve(2);

      repeat (20) @(negedge clk);
      chk("pkt_q_empty",  pkt_q.size(), 32'd0);
      chk("done_q_empty", done_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
